// File: rtl/mul_arbiter_if.sv
// Bundle between four requesters, the arbiter and a shared multiplier.
// slave = arbiter side, master = requester/multiplier side.
interface mul_arbiter_if #(parameter int N = 8);
   logic [3:0]     req;
   logic [4*N-1:0] a_in;
   logic [4*N-1:0] b_in;
   logic [3:0]     ack;
   logic           rsp_valid;
   logic [1:0]     rsp_id;
   logic [2*N-1:0] rsp_data;
   logic           mul_start;
   logic [N-1:0]   mul_m1;
   logic [N-1:0]   mul_m2;
   logic           mul_done;
   logic [2*N-1:0] mul_out;
   logic           busy;
   logic           err;

   modport slave (
      input  req, a_in, b_in, mul_done, mul_out,
      output ack, rsp_valid, rsp_id, rsp_data, mul_start, mul_m1, mul_m2, busy, err
   );

   modport master (
      output req, a_in, b_in, mul_done, mul_out,
      input  ack, rsp_valid, rsp_id, rsp_data, mul_start, mul_m1, mul_m2, busy, err
   );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one multi-cycle multiplier among four requesters.
// Optional WAIT timeout enabled by defining MUL_ARB_TIMEOUT_EN.
module mul_arbiter #(
   parameter int N       = 8,
   parameter int TIMEOUT = 64
) (
   input logic           clk,
   input logic           rst_n,
   mul_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

   state_t         state_q, state_d;
   logic [1:0]     last_q, last_d;
   logic [1:0]     id_q, id_d;
   logic [N-1:0]   m1_q, m1_d, m2_q, m2_d;
   logic [3:0]     ack_q, ack_d;
   logic           start_q, start_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic [1:0]     rsp_id_q, rsp_id_d;
   logic [2*N-1:0] rsp_data_q, rsp_data_d;

   logic           gnt_vld;
   logic [1:0]     gnt_id;
   logic [1:0]     idx;

`ifdef MUL_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0]  tmo_q, tmo_d;
   logic           err_q, err_d;
`endif

   // Search starts just above the last served requester and wraps back to it.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = last_q;
      idx     = last_q;
      for (int i = 1; i <= 4; i++) begin
         idx = last_q + 2'(i);
         if (!gnt_vld && bus.req[idx]) begin
            gnt_vld = 1'b1;
            gnt_id  = idx;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      id_d        = id_q;
      m1_d        = m1_q;
      m2_d        = m2_q;
      ack_d       = '0;
      start_d     = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
`ifdef MUL_ARB_TIMEOUT_EN
      tmo_d       = tmo_q;
      err_d       = err_q;
`endif
      case (state_q)
         IDLE: if (gnt_vld) begin
            state_d        = LAUNCH;
            id_d           = gnt_id;
            m1_d           = bus.a_in[gnt_id*N +: N];
            m2_d           = bus.b_in[gnt_id*N +: N];
            ack_d[gnt_id]  = 1'b1;
            start_d        = 1'b1;
         end
         LAUNCH: begin
            state_d = WAIT;
`ifdef MUL_ARB_TIMEOUT_EN
            tmo_d   = '0;
`endif
         end
         WAIT: if (bus.mul_done) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
            rsp_data_d  = bus.mul_out;
`ifdef MUL_ARB_TIMEOUT_EN
            err_d       = 1'b0;
         end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            // Give up on the multiplier and answer with a flagged zero.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
            rsp_data_d  = '0;
            err_d       = 1'b1;
         end else begin
            tmo_d       = tmo_q + 1'b1;
`endif
         end
         RESP: begin
            state_d = IDLE;
            last_d  = rsp_id_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_q      <= 2'd3;
         id_q        <= '0;
         m1_q        <= '0;
         m2_q        <= '0;
         ack_q       <= '0;
         start_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
         tmo_q       <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         id_q        <= id_d;
         m1_q        <= m1_d;
         m2_q        <= m2_d;
         ack_q       <= ack_d;
         start_q     <= start_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
`ifdef MUL_ARB_TIMEOUT_EN
         tmo_q       <= tmo_d;
         err_q       <= err_d;
`endif
      end
   end

   assign bus.ack       = ack_q;
   assign bus.mul_start = start_q;
   assign bus.mul_m1    = m1_q;
   assign bus.mul_m2    = m2_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.busy      = (state_q != IDLE);
`ifdef MUL_ARB_TIMEOUT_EN
   assign bus.err       = err_q;
`else
   assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a 9-cycle behavioural signed multiplier.
module tb_mul_arbiter;
`ifdef MUL_ARB_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 64;
`endif
   localparam int LAT = 9;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mul_arbiter_if #(.N(8)) bus ();
   mul_arbiter #(.N(8), .TIMEOUT(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   // behavioural multiplier: done on the LAT-th cycle after the start edge
   logic [3:0]         cnt;
   logic signed [15:0] prod;
   logic               model_en = 1'b1;
   logic               tb_done  = 1'b0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         prod <= '0;
      end else if (bus.mul_start) begin
         cnt  <= 4'(LAT);
         prod <= 16'($signed(bus.mul_m1) * $signed(bus.mul_m2));
      end else if (cnt != 0) begin
         cnt  <= cnt - 1'b1;
      end
   end
   assign bus.mul_done = (model_en && cnt == 4'd1) || tb_done;
   assign bus.mul_out  = prod;

   int grants[$];
   int rids[$];
   logic [15:0] rdat[$];
   int rsp_cnt = 0;
   int viol = 0;
   int passed = 0;
   int total = 0;

   function automatic int oh2id(input logic [3:0] oh);
      int r = 0;
      for (int i = 0; i < 4; i++) if (oh[i]) r = i;
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if ($countones(bus.ack) > 1 || (|bus.ack && bus.rsp_valid)) viol++;
         if (|bus.ack) grants.push_back(oh2id(bus.ack));
         if (bus.rsp_valid) begin
            rsp_cnt++;
            rids.push_back(int'(bus.rsp_id));
            rdat.push_back(bus.rsp_data);
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic wait_rsp(input int max, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.rsp_valid && n < max);
      chk("rsp_seen", 64'(bus.rsp_valid), 64'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      grants.delete();
      rids.delete();
      rdat.delete();
   endtask

   function automatic logic [63:0] all_out();
      return 64'({bus.ack, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.mul_start,
                  bus.mul_m1, bus.mul_m2, bus.busy, bus.err});
   endfunction

   initial begin
      int n;
      int snap;
      bus.req  = '0;
      bus.a_in = '0;
      bus.b_in = '0;

      // reset state
      repeat (2) @(negedge clk);
      chk("reset_outputs", all_out(), 64'd0);
      rst_n = 1'b1;

      // single request: 5 * -3
      bus.a_in = 32'h0000_0005;
      bus.b_in = 32'h0000_00FD;
      bus.req  = 4'b0001;
      @(negedge clk);
      chk("t1_ack", 64'(bus.ack), 64'h1);
      chk("t1_start", 64'(bus.mul_start), 64'h1);
      chk("t1_busy", 64'(bus.busy), 64'h1);
      chk("t1_ops", 64'({bus.mul_m1, bus.mul_m2}), 64'h05FD);
      bus.req = '0;
      wait_rsp(50, n);
      chk("t1_latency", 64'(n), 64'd10);
      chk("t1_rsp_id", 64'(bus.rsp_id), 64'd0);
      chk("t1_rsp_data", 64'(bus.rsp_data), 64'hFFF1);
      chk("t1_err", 64'(bus.err), 64'd0);
      chk("t1_ops_held", 64'({bus.mul_m1, bus.mul_m2}), 64'h05FD);
      @(negedge clk);
      chk("t1_idle", 64'({bus.busy, bus.rsp_valid}), 64'd0);
      chk("t1_data_hold", 64'(bus.rsp_data), 64'hFFF1);
      chk("t1_one_ack", 64'(grants.size()), 64'd1);

      // all four requesting: round-robin from requester 0
      do_reset();
      bus.a_in = 32'h0A_80_04_01;
      bus.b_in = 32'h05_80_FD_FE;
      bus.req  = 4'b1111;
      for (int k = 0; k < 5; k++) wait_rsp(50, n);
      bus.req = '0;
      #1;
      chk("t2_nacks", 64'(grants.size()), 64'd5);
      chk("t2_nrsp", 64'(rdat.size()), 64'd5);
      if (grants.size() == 5 && rdat.size() == 5) begin
         chk("t2_g0", 64'(grants[0]), 64'd0);
         chk("t2_g1", 64'(grants[1]), 64'd1);
         chk("t2_g2", 64'(grants[2]), 64'd2);
         chk("t2_g3", 64'(grants[3]), 64'd3);
         chk("t2_g4", 64'(grants[4]), 64'd0);
         chk("t2_id3", 64'(rids[3]), 64'd3);
         chk("t2_d0", 64'(rdat[0]), 64'hFFFE);
         chk("t2_d1", 64'(rdat[1]), 64'hFFF4);
         chk("t2_d2", 64'(rdat[2]), 64'h4000);
         chk("t2_d3", 64'(rdat[3]), 64'h0032);
         chk("t2_d4", 64'(rdat[4]), 64'hFFFE);
      end

      // requests landing during requester 0's WAIT
      do_reset();
      bus.req = 4'b0001;
      @(negedge clk);
      bus.req = '0;
      @(negedge clk);
      bus.req = 4'b0011;
      for (int k = 0; k < 3; k++) wait_rsp(50, n);
      bus.req = '0;
      #1;
      chk("t3_nacks", 64'(grants.size()), 64'd3);
      if (grants.size() == 3) begin
         chk("t3_g0", 64'(grants[0]), 64'd0);
         chk("t3_g1", 64'(grants[1]), 64'd1);
         chk("t3_g2", 64'(grants[2]), 64'd0);
      end

      // reset mid-WAIT
      do_reset();
      bus.req = 4'b0001;
      @(negedge clk);
      bus.req = '0;
      repeat (3) @(negedge clk);
      snap = rsp_cnt;
      rst_n = 1'b0;
      #1;
      chk("t4_reset_outputs", all_out(), 64'd0);
      repeat (2) @(negedge clk);
      chk("t4_no_rsp", 64'(rsp_cnt), 64'(snap));
      rst_n = 1'b1;
      bus.req = 4'b1010;
      @(negedge clk);
      chk("t4_ack1", 64'(bus.ack), 64'b0010);
      bus.req = '0;
      wait_rsp(50, n);
      chk("t4_rsp_id", 64'(bus.rsp_id), 64'd1);
      chk("t4_rsp_data", 64'(bus.rsp_data), 64'hFFF4);
      #1;
      chk("t4_rsp_cnt", 64'(rsp_cnt), 64'(snap + 1));

      // stray mul_done in IDLE
      @(negedge clk);
      snap = rsp_cnt;
      tb_done = 1'b1;
      @(negedge clk);
      tb_done = 1'b0;
      chk("t5_idle", 64'({bus.busy, bus.rsp_valid, bus.ack}), 64'd0);
      repeat (3) @(negedge clk);
      chk("t5_no_rsp", 64'(rsp_cnt), 64'(snap));
      chk("t5_data_hold", 64'(bus.rsp_data), 64'hFFF4);

`ifdef MUL_ARB_TIMEOUT_EN
      // multiplier never answers
      model_en = 1'b0;
      bus.req = 4'b0001;
      @(negedge clk);
      bus.req = '0;
      wait_rsp(40, n);
      chk("t6_latency", 64'(n), 64'd17);
      chk("t6_err", 64'(bus.err), 64'd1);
      chk("t6_data", 64'(bus.rsp_data), 64'd0);
      chk("t6_id", 64'(bus.rsp_id), 64'd0);
      model_en = 1'b1;
`endif

      chk("ack_exclusive", 64'(viol), 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
